// File: rtl/header_creator_pkg.sv
// header_creator_pkg: types shared by the header creator and its ingress packet buffer.
// Descriptor fields are sized for the largest supported data buffer (FEEDER_DEPTH_MAX words).

`ifndef BUS_WIDTH_BITS
`define BUS_WIDTH_BITS 32
`endif

package header_creator_pkg;

    localparam int FEEDER_DROP_CNT_W = 16;
    localparam int FEEDER_DEPTH_MAX  = 64;
    // Holds a pointer with its wrap bit, or a length of up to FEEDER_DEPTH_MAX words.
    localparam int FEEDER_DESC_W     = $clog2(FEEDER_DEPTH_MAX) + 1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STREAM,
        RD_GAP
    } FEEDER_RD_STATES;

    typedef struct packed {
        logic [FEEDER_DESC_W-1:0] base;
        logic [FEEDER_DESC_W-1:0] len;
    } FEEDER_DESC;

endpackage

// File: rtl/hc_desc_fifo.sv
// hc_desc_fifo: synchronous FIFO of committed packet descriptors with an occupancy count.
// pop_desc_o shows the head entry combinationally; push when full and pop when empty are ignored.
module hc_desc_fifo
    import header_creator_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  FEEDER_DESC               push_desc_i,
    input  logic                     pop_i,
    output FEEDER_DESC               pop_desc_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    FEEDER_DESC    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o     = (cnt_q == CNT_MAX);
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign pop_desc_o = mem_q[rd_q];
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;

    // Advance pointers and occupancy for the accepted push/pop pair.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + PTR_ONE;
        if (pop_ok)  rd_d = rd_q + PTR_ONE;
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_ONE;
        else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_ONE;
    end

    // Descriptor storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_desc_i;
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/n3_ingress_packet_buffer.sv
// n3_ingress_packet_buffer: store-and-forward N3 packet buffer feeding the N3-to-N6 header creator.
// Packets are committed on EOP and replayed whole on request; oversized/truncated packets are dropped.
// Optional feature: define N3_FEEDER_PKT_ID_EN to number emitted packets on packet_id_o.
module n3_ingress_packet_buffer
    import header_creator_pkg::*;
#(
    parameter int unsigned BUS_W    = `BUS_WIDTH_BITS,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned MAX_PKTS = 8
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          in_valid_i,
    input  logic                          in_sop_i,
    input  logic                          in_eop_i,
    input  logic [BUS_W-1:0]              in_data_i,
    output logic                          in_ready_o,
    input  logic                          packet_read_req_i,
    output logic [BUS_W-1:0]              packet_bus_o,
    output logic                          start_of_packet_o,
    output logic                          packet_valid_o,
    output logic                          end_of_packet_o,
    output logic [$clog2(MAX_PKTS):0]     pkt_count_o,
    output logic [FEEDER_DROP_CNT_W-1:0]  drop_count_o,
    output logic [15:0]                   packet_id_o
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] ONE_W   = 1;
    localparam logic [PTR_W:0] DEPTH_W = (PTR_W+1)'(DEPTH);

    // Saturating add for the drop counter (up to two drops can land in one cycle).
    function automatic logic [FEEDER_DROP_CNT_W-1:0] sat_add(
        input logic [FEEDER_DROP_CNT_W-1:0] a, input logic [1:0] b);
        logic [FEEDER_DROP_CNT_W:0] s;
        s = {1'b0, a} + {{(FEEDER_DROP_CNT_W-1){1'b0}}, b};
        return s[FEEDER_DROP_CNT_W] ? '1 : s[FEEDER_DROP_CNT_W-1:0];
    endfunction

    // True when writing at wp would overrun words the read side has not yet consumed.
    function automatic logic no_room(input logic [PTR_W:0] wp, input logic [PTR_W:0] rp);
        logic [PTR_W:0] used;
        used = wp - rp;
        return used == DEPTH_W;
    endfunction

    logic [BUS_W-1:0]             buf_q [DEPTH];
    logic [PTR_W:0]               wr_ptr_q, wr_ptr_d, pkt_base_q, pkt_base_d, wr_len_q, wr_len_d;
    logic [PTR_W:0]               rd_ptr_q, rd_ptr_d, rem_q, rem_d, sop_wp, pop_base, pop_len;
    logic                         open_q, open_d, accept, buf_we;
    logic [PTR_W-1:0]             buf_waddr, rd_addr;
    logic [1:0]                   drop_inc;
    logic [FEEDER_DROP_CNT_W-1:0] drop_cnt_q;
    logic                         desc_push, desc_pop, desc_full, desc_empty;
    FEEDER_DESC                   push_desc, pop_desc;
    FEEDER_RD_STATES              state_q, state_d;
    logic [BUS_W-1:0]             bus_q, bus_d;
    logic                         sop_q, sop_d, vld_q, vld_d, eop_q, eop_d;

    assign in_ready_o = !desc_full;
    assign accept     = in_valid_i && in_ready_o;
    assign desc_pop   = (state_q == RD_IDLE) && packet_read_req_i && !desc_empty;
    assign pop_base   = pop_desc.base[PTR_W:0];
    assign pop_len    = pop_desc.len[PTR_W:0];

    // Write side: place words, track the open packet, commit on EOP, rewind on a drop.
    // A SOP into an open packet restarts at that packet's base, reusing the truncated space.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        pkt_base_d     = pkt_base_q;
        wr_len_d       = wr_len_q;
        open_d         = open_q;
        drop_inc       = 2'd0;
        buf_we         = 1'b0;
        buf_waddr      = wr_ptr_q[PTR_W-1:0];
        desc_push      = 1'b0;
        sop_wp         = open_q ? pkt_base_q : wr_ptr_q;
        push_desc.base = FEEDER_DESC_W'(pkt_base_q);
        push_desc.len  = FEEDER_DESC_W'(wr_len_q);
        if (accept && in_sop_i) begin
            if (open_q) drop_inc = drop_inc + 2'd1;
            if (no_room(sop_wp, rd_ptr_q)) begin
                drop_inc = drop_inc + 2'd1;
                open_d   = 1'b0;
                wr_ptr_d = sop_wp;
            end else begin
                buf_we         = 1'b1;
                buf_waddr      = sop_wp[PTR_W-1:0];
                wr_ptr_d       = sop_wp + ONE_W;
                pkt_base_d     = sop_wp;
                wr_len_d       = ONE_W;
                open_d         = !in_eop_i;
                desc_push      = in_eop_i;
                push_desc.base = FEEDER_DESC_W'(sop_wp);
                push_desc.len  = FEEDER_DESC_W'(ONE_W);
            end
        end else if (accept && open_q) begin
            if (wr_len_q == DEPTH_W || no_room(wr_ptr_q, rd_ptr_q)) begin
                drop_inc = 2'd1;
                open_d   = 1'b0;
                wr_ptr_d = pkt_base_q;
            end else begin
                buf_we        = 1'b1;
                wr_ptr_d      = wr_ptr_q + ONE_W;
                wr_len_d      = wr_len_q + ONE_W;
                open_d        = !in_eop_i;
                desc_push     = in_eop_i;
                push_desc.len = FEEDER_DESC_W'(wr_len_q + ONE_W);
            end
        end
    end

    // Packet data RAM; no reset so it can map onto memory primitives.
    always_ff @(posedge CLK) begin
        if (buf_we) buf_q[buf_waddr] <= in_data_i;
    end

    // Write-side control registers and drop counter.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            pkt_base_q <= '0;
            wr_len_q   <= '0;
            open_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            pkt_base_q <= pkt_base_d;
            wr_len_q   <= wr_len_d;
            open_q     <= open_d;
            drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
        end
    end

    hc_desc_fifo #(
        .DEPTH (MAX_PKTS)
    ) u_desc_fifo (
        .clk         (CLK),
        .rst_n       (reset),
        .push_i      (desc_push),
        .push_desc_i (push_desc),
        .pop_i       (desc_pop),
        .pop_desc_o  (pop_desc),
        .full_o      (desc_full),
        .empty_o     (desc_empty),
        .count_o     (pkt_count_o)
    );

    // Read FSM state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= RD_IDLE;
        else        state_q <= state_d;
    end

    // Read FSM next state: a one-word packet skips straight to the gap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:   if (desc_pop) state_d = (pop_len == ONE_W) ? RD_GAP : RD_STREAM;
            RD_STREAM: if (rem_q == ONE_W) state_d = RD_GAP;
            RD_GAP:    state_d = RD_IDLE;
            default:   state_d = RD_IDLE;
        endcase
    end

    // Read FSM outputs: next egress word/strobes and read pointer; space frees word by word.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        rem_d    = rem_q;
        rd_addr  = rd_ptr_q[PTR_W-1:0];
        bus_d    = '0;
        sop_d    = 1'b0;
        vld_d    = 1'b0;
        eop_d    = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (desc_pop) begin
                    rd_addr  = pop_base[PTR_W-1:0];
                    bus_d    = buf_q[rd_addr];
                    sop_d    = 1'b1;
                    vld_d    = 1'b1;
                    eop_d    = (pop_len == ONE_W);
                    rd_ptr_d = pop_base + ONE_W;
                    rem_d    = pop_len - ONE_W;
                end
            end
            RD_STREAM: begin
                bus_d    = buf_q[rd_addr];
                vld_d    = 1'b1;
                eop_d    = (rem_q == ONE_W);
                rd_ptr_d = rd_ptr_q + ONE_W;
                rem_d    = rem_q - ONE_W;
            end
            default: ;
        endcase
    end

    // Registered egress and read pointer; reset aborts any packet in flight.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            rem_q    <= '0;
            bus_q    <= '0;
            sop_q    <= 1'b0;
            vld_q    <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            rem_q    <= rem_d;
            bus_q    <= bus_d;
            sop_q    <= sop_d;
            vld_q    <= vld_d;
            eop_q    <= eop_d;
        end
    end

    assign packet_bus_o      = bus_q;
    assign start_of_packet_o = sop_q;
    assign packet_valid_o    = vld_q;
    assign end_of_packet_o   = eop_q;
    assign drop_count_o      = drop_cnt_q;

`ifdef N3_FEEDER_PKT_ID_EN
    logic [15:0] pkt_id_q, pkt_id_d;

    // Packet ID advances with each emitted SOP and holds for the rest of the packet.
    always_comb begin
        pkt_id_d = desc_pop ? pkt_id_q + 16'd1 : pkt_id_q;
    end

    // Packet ID register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) pkt_id_q <= '0;
        else        pkt_id_q <= pkt_id_d;
    end

    assign packet_id_o = pkt_id_q;
`else
    assign packet_id_o = 16'd0;
`endif

endmodule
